// File: rtl/battleship_pkg.sv
// Shared types and constants for the battleship board: cell encodings, pixel pitches and
// scheduler states.
package battleship_pkg;

    typedef enum logic [1:0] {
        EMPTY = 2'b00,
        SHIP  = 2'b01,
        HIT   = 2'b10,
        MISS  = 2'b11
    } cell_status_e;

    localparam int unsigned ROW_PERIOD  = 48;
    localparam int unsigned LINE_PERIOD = 64;
    localparam int unsigned BOARD_CELLS = 100;

    typedef enum logic [1:0] {
        IDLE,
        CLEAR,
        FIRE_RD,
        FIRE_WR
    } sched_state_e;

    // Result of firing at a cell: ships become hits, water becomes a miss, old shots stay.
    function automatic logic [1:0] fire_update(input logic [1:0] status);
        logic [1:0] result;
        unique case (status)
            SHIP:    result = HIT;
            EMPTY:   result = MISS;
            default: result = status;
        endcase
        return result;
    endfunction

    function automatic logic [6:0] cell_index(input logic [3:0] x, input logic [3:0] y,
                                              input int unsigned cols);
        return 7'((32'(y) * cols) + 32'(x));
    endfunction

endpackage

// File: rtl/pixel_to_cell.sv
// Combinational mapping of a pixel coordinate onto a board cell, with an in-range flag.
module pixel_to_cell
    import battleship_pkg::*;
#(
    parameter int unsigned COLS = 10,
    parameter int unsigned ROWS = 10
) (
    input  logic [9:0] row,
    input  logic [9:0] line,
    output logic [3:0] x,
    output logic [3:0] y,
    output logic       in_range
);

    always_comb begin
        x = 4'(line / 10'(LINE_PERIOD));
        // Row pitch is not a power of two: count the multiples of 48 already passed,
        // saturating at 15 (anything that large is off the board anyway).
        y = '0;
        for (int unsigned k = 1; k <= 15; k++) begin
            if ({22'd0, row} >= k * ROW_PERIOD) begin
                y = 4'(k);
            end
        end
        in_range = (32'(x) < COLS) && (32'(y) < ROWS);
    end

endmodule

// File: rtl/board_cell_scheduler.sv
// Owns the battleship board, serves the per-pixel display lookup and grants writes, fires
// and clears only during blanking.
module board_cell_scheduler
    import battleship_pkg::*;
#(
    parameter int unsigned COLS = 10,
    parameter int unsigned ROWS = 10
) (
    input  logic       clk_in,
    input  logic       rst_n_in,
    input  logic       enable,
    input  logic [9:0] current_row,
    input  logic [9:0] current_line,
    input  logic       wr_valid,
    output logic       wr_ready,
    input  logic [3:0] wr_x,
    input  logic [3:0] wr_y,
    input  logic [1:0] wr_status,
    input  logic       fire_valid,
    output logic       fire_ready,
    input  logic [3:0] fire_x,
    input  logic [3:0] fire_y,
    output logic       fire_done,
    output logic [1:0] fire_result,
    output logic       fire_err,
    input  logic       clear_req,
    output logic       clear_done,
    output logic       busy,
    output logic [1:0] cell_status,
    output logic [3:0] cell_x,
    output logic [3:0] cell_y
);

    localparam int unsigned CELLS = COLS * ROWS;

    logic [1:0]   board_q [CELLS];
    sched_state_e state_q, state_d;
    logic [6:0]   idx_q, idx_d;
    logic [3:0]   fx_q, fx_d, fy_q, fy_d;
    logic [1:0]   rd_q, rd_d;

    logic         board_we;
    logic [6:0]   board_idx;
    logic [1:0]   board_data;

    logic [3:0]   pix_x, pix_y;
    logic         pix_in_range;
    logic [6:0]   pix_idx;
    logic         wr_in_range, fire_in_range;
    logic [6:0]   fire_idx;
    logic [1:0]   fire_new;

    pixel_to_cell #(
        .COLS (COLS),
        .ROWS (ROWS)
    ) u_pixel_to_cell (
        .row      (current_row),
        .line     (current_line),
        .x        (pix_x),
        .y        (pix_y),
        .in_range (pix_in_range)
    );

    assign pix_idx       = cell_index(pix_x, pix_y, COLS);
    assign wr_in_range   = (32'(wr_x) < COLS) && (32'(wr_y) < ROWS);
    assign fire_in_range = (32'(fx_q) < COLS) && (32'(fy_q) < ROWS);
    assign fire_idx      = cell_index(fx_q, fy_q, COLS);
    assign fire_new      = fire_update(rd_q);
    assign busy          = (state_q != IDLE);

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        fx_d        = fx_q;
        fy_d        = fy_q;
        rd_d        = rd_q;
        board_we    = 1'b0;
        board_idx   = '0;
        board_data  = EMPTY;
        fire_ready  = 1'b0;
        wr_ready    = 1'b0;
        fire_done   = 1'b0;
        fire_result = EMPTY;
        fire_err    = 1'b0;
        clear_done  = 1'b0;

        unique case (state_q)
            IDLE: begin
                fire_ready = !enable && !clear_req;
                wr_ready   = fire_ready && !fire_valid;
                if (!enable && clear_req) begin
                    state_d = CLEAR;
                    idx_d   = '0;
                end else if (fire_valid && fire_ready) begin
                    fx_d    = fire_x;
                    fy_d    = fire_y;
                    state_d = FIRE_RD;
                end else if (wr_valid && wr_ready && wr_in_range) begin
                    board_we   = 1'b1;
                    board_idx  = cell_index(wr_x, wr_y, COLS);
                    board_data = wr_status;
                end
            end
            CLEAR: begin
                board_we  = 1'b1;
                board_idx = idx_q;
                if (idx_q == 7'(CELLS - 1)) begin
                    clear_done = 1'b1;
                    state_d    = IDLE;
                end else begin
                    idx_d = idx_q + 7'd1;
                end
            end
            FIRE_RD: begin
                rd_d    = fire_in_range ? board_q[fire_idx] : EMPTY;
                state_d = FIRE_WR;
            end
            FIRE_WR: begin
                fire_done = 1'b1;
                state_d   = IDLE;
                if (fire_in_range) begin
                    board_we    = 1'b1;
                    board_idx   = fire_idx;
                    board_data  = fire_new;
                    fire_result = fire_new;
                end else begin
                    fire_err = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state_q <= IDLE;
            idx_q   <= '0;
            fx_q    <= '0;
            fy_q    <= '0;
            rd_q    <= EMPTY;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            fx_q    <= fx_d;
            fy_q    <= fy_d;
            rd_q    <= rd_d;
        end
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            for (int unsigned i = 0; i < CELLS; i++) begin
                board_q[i] <= EMPTY;
            end
        end else if (board_we) begin
            board_q[board_idx] <= board_data;
        end
    end

    // A half-cleared board is never shown: status reads as empty for the whole sweep.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            cell_status <= EMPTY;
            cell_x      <= 4'hF;
            cell_y      <= 4'hF;
        end else begin
            if (state_q == CLEAR) begin
                cell_status <= EMPTY;
            end
            if (enable) begin
                cell_x <= pix_in_range ? pix_x : 4'hF;
                cell_y <= pix_in_range ? pix_y : 4'hF;
                if (state_q != CLEAR) begin
                    cell_status <= pix_in_range ? board_q[pix_idx] : EMPTY;
                end
            end
        end
    end

endmodule

// File: tb/tb_board_cell_scheduler.sv
// Directed bench for board_cell_scheduler with a cycle-level reference model of the board.
module tb_board_cell_scheduler;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       enable;
    logic [9:0] current_row, current_line;
    logic       wr_valid, wr_ready;
    logic [3:0] wr_x, wr_y;
    logic [1:0] wr_status;
    logic       fire_valid, fire_ready;
    logic [3:0] fire_x, fire_y;
    logic       fire_done, fire_err;
    logic [1:0] fire_result;
    logic       clear_req, clear_done, busy;
    logic [1:0] cell_status;
    logic [3:0] cell_x, cell_y;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    board_cell_scheduler #(
        .COLS (10),
        .ROWS (10)
    ) dut (
        .clk_in       (clk),
        .rst_n_in     (rst_n),
        .enable       (enable),
        .current_row  (current_row),
        .current_line (current_line),
        .wr_valid     (wr_valid),
        .wr_ready     (wr_ready),
        .wr_x         (wr_x),
        .wr_y         (wr_y),
        .wr_status    (wr_status),
        .fire_valid   (fire_valid),
        .fire_ready   (fire_ready),
        .fire_x       (fire_x),
        .fire_y       (fire_y),
        .fire_done    (fire_done),
        .fire_result  (fire_result),
        .fire_err     (fire_err),
        .clear_req    (clear_req),
        .clear_done   (clear_done),
        .busy         (busy),
        .cell_status  (cell_status),
        .cell_x       (cell_x),
        .cell_y       (cell_y)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: board contents, the operation in progress (0 none, 1 clear, 2 fire)
    // with cycles spent in it, and the registered display values.
    int m_board [100];
    int m_op, m_cnt, m_fx, m_fy;
    int e_status, e_x, e_y;
    int mpx, mpy;
    bit minr;

    function automatic int shot(input int s);
        if (s == 1) return 2;
        if (s == 0) return 3;
        return s;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 100; i++) m_board[i] = 0;
            m_op = 0; m_cnt = 0; m_fx = 0; m_fy = 0;
            e_status = 0; e_x = 15; e_y = 15;
        end else begin
            mpx  = int'(current_line) / 64;
            mpy  = int'(current_row) / 48;
            minr = (mpx < 10) && (mpy < 10);
            if (m_op == 1) e_status = 0;
            if (enable) begin
                e_x = minr ? mpx : 15;
                e_y = minr ? mpy : 15;
                if (m_op != 1) e_status = minr ? m_board[mpy * 10 + mpx] : 0;
            end
            case (m_op)
                0: if (!enable) begin
                    if (clear_req) begin
                        m_op = 1; m_cnt = 0;
                    end else if (fire_valid) begin
                        m_op = 2; m_cnt = 0; m_fx = int'(fire_x); m_fy = int'(fire_y);
                    end else if (wr_valid && wr_x < 10 && wr_y < 10) begin
                        m_board[int'(wr_y) * 10 + int'(wr_x)] = int'(wr_status);
                    end
                end
                1: begin
                    m_board[m_cnt] = 0;
                    if (m_cnt == 99) m_op = 0;
                    else m_cnt++;
                end
                default: begin
                    if (m_cnt == 0) begin
                        m_cnt = 1;
                    end else begin
                        if (m_fx < 10 && m_fy < 10)
                            m_board[m_fy * 10 + m_fx] = shot(m_board[m_fy * 10 + m_fx]);
                        m_op = 0;
                    end
                end
            endcase
        end
    end

    bit x_idle, x_done, x_inr;
    always @(negedge clk) begin
        if (rst_n) begin
            x_idle = (m_op == 0) && !enable && !clear_req;
            x_done = (m_op == 2) && (m_cnt == 1);
            x_inr  = (m_fx < 10) && (m_fy < 10);
            check("m_busy", busy, m_op != 0);
            check("m_fire_ready", fire_ready, x_idle);
            check("m_wr_ready", wr_ready, x_idle && !fire_valid);
            check("m_fire_done", fire_done, x_done);
            check("m_clear_done", clear_done, (m_op == 1) && (m_cnt == 99));
            check("m_cell_status", cell_status, e_status);
            check("m_cell_x", cell_x, e_x);
            check("m_cell_y", cell_y, e_y);
            if (x_done) begin
                check("m_fire_result", fire_result,
                      x_inr ? shot(m_board[m_fy * 10 + m_fx]) : 0);
                check("m_fire_err", fire_err, !x_inr);
            end
        end
    end

    task automatic do_write(input int x, input int y, input int s);
        int k = 0;
        wr_valid = 1'b1; wr_x = 4'(x); wr_y = 4'(y); wr_status = 2'(s);
        #1;
        while (!wr_ready && k < 200) begin
            @(posedge clk); #1; k++;
        end
        if (!wr_ready) check("wr_grant_timeout", 0, 1);
        @(posedge clk); #1;
        wr_valid = 1'b0;
    endtask

    task automatic do_fire(input int x, input int y, output int res, output int err);
        int k = 0;
        fire_valid = 1'b1; fire_x = 4'(x); fire_y = 4'(y);
        #1;
        while (!fire_ready && k < 200) begin
            @(posedge clk); #1; k++;
        end
        if (!fire_ready) check("fire_grant_timeout", 0, 1);
        @(posedge clk); #1;
        fire_valid = 1'b0;
        check("fire_busy_rd", busy, 1);
        @(posedge clk); #1;
        check("fire_done_latency", fire_done, 1);
        res = int'(fire_result);
        err = int'(fire_err);
    endtask

    task automatic show(input int line, input int row);
        enable = 1'b1; current_line = 10'(line); current_row = 10'(row);
        @(posedge clk); #1;
        enable = 1'b0;
    endtask

    int res, err, k;

    initial begin
        rst_n = 1'b0; enable = 1'b0; current_row = '0; current_line = '0;
        wr_valid = 1'b0; wr_x = '0; wr_y = '0; wr_status = '0;
        fire_valid = 1'b0; fire_x = '0; fire_y = '0; clear_req = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_cell_status", cell_status, 0);
        check("rst_cell_x", cell_x, 15);
        check("rst_cell_y", cell_y, 15);
        check("rst_busy", busy, 0);
        check("rst_fire_done", fire_done, 0);
        check("rst_clear_done", clear_done, 0);
        rst_n = 1'b1;

        show(130, 100);
        check("disp_x_2", cell_x, 2);
        check("disp_y_2", cell_y, 2);
        check("disp_status_empty", cell_status, 0);

        do_write(3, 4, 1);
        show(200, 200);
        check("disp_x_3", cell_x, 3);
        check("disp_y_4", cell_y, 4);
        check("disp_status_ship", cell_status, 1);

        do_fire(3, 4, res, err);
        check("fire_ship_hit", res, 2);
        check("fire_ship_err", err, 0);
        do_fire(3, 4, res, err);
        check("fire_again_hit", res, 2);
        do_fire(0, 0, res, err);
        check("fire_water_miss", res, 3);

        enable = 1'b1; wr_valid = 1'b1; wr_x = 4'd5; wr_y = 4'd5; wr_status = 2'd1;
        repeat (4) begin
            @(posedge clk); #1;
            check("wr_ready_active_video", wr_ready, 0);
        end
        enable = 1'b0; #1;
        check("wr_ready_first_blank", wr_ready, 1);
        @(posedge clk); #1;
        wr_valid = 1'b0;
        show(330, 241);
        check("held_write_landed", cell_status, 1);

        // Clear, fire and write all requested together: clear first, then the fire.
        clear_req = 1'b1;
        fire_valid = 1'b1; fire_x = 4'd5; fire_y = 4'd5;
        wr_valid = 1'b1; wr_x = 4'd1; wr_y = 4'd1; wr_status = 2'd1;
        @(posedge clk); #1;
        clear_req = 1'b0;
        check("clear_wins_busy", busy, 1);
        k = 1;
        while (!clear_done && k < 150) begin
            @(posedge clk); #1; k++;
        end
        check("clear_done_cycle", k, 100);
        @(posedge clk); #1;
        check("post_clear_fire_ready", fire_ready, 1);
        check("post_clear_wr_blocked", wr_ready, 0);
        @(posedge clk); #1;
        fire_valid = 1'b0; wr_valid = 1'b0;
        check("post_clear_fire_busy", busy, 1);
        @(posedge clk); #1;
        check("post_clear_fire_done", fire_done, 1);
        check("post_clear_fire_miss", fire_result, 3);
        for (int y = 0; y < 10; y++) begin
            for (int x = 0; x < 10; x++) begin
                show(x * 64 + 32, y * 48 + 24);
                check("cleared_board", cell_status, (x == 5 && y == 5) ? 3 : 0);
            end
        end

        do_write(0, 0, 1);
        do_fire(12, 0, res, err);
        check("fire_oor_err", err, 1);
        check("fire_oor_result", res, 0);
        show(10, 10);
        check("fire_oor_board_kept", cell_status, 1);
        show(700, 10);
        check("offboard_x", cell_x, 15);
        check("offboard_status", cell_status, 0);
        show(10, 10);

        // Reset in the middle of a clear, at sweep index 50.
        do_write(3, 7, 1);
        clear_req = 1'b1;
        @(posedge clk); #1;
        clear_req = 1'b0;
        repeat (50) @(posedge clk);
        #1;
        check("mid_clear_busy", busy, 1);
        rst_n = 1'b0; #1;
        check("rst_mid_busy", busy, 0);
        check("rst_mid_cell_status", cell_status, 0);
        check("rst_mid_cell_x", cell_x, 15);
        check("rst_mid_cell_y", cell_y, 15);
        check("rst_mid_clear_done", clear_done, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        show(3 * 64 + 5, 7 * 48 + 5);
        check("rst_board_cleared", cell_status, 0);
        check("rst_board_x", cell_x, 3);
        check("rst_board_y", cell_y, 7);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/board_cell_scheduler.md
# board_cell_scheduler

Owns the 10x10 battleship board (100 cells x 2 bits) and schedules all accesses to it. Each clock, during active video, it looks up the cell under the current pixel and presents `cell_status`/`cell_x`/`cell_y` to `Module_VGADriver`. Game-logic writes, fire (read-modify-write) requests and full-board clears are granted only during blanking, so they never disturb the displayed frame mid-line.

## Interface
- `COLS`, default 10: board columns (x, along `current_line`).
- `ROWS`, default 10: board rows (y, along `current_row`).
- `clk_in`  in  1  pixel clock, shared with the VGA driver.
- `rst_n_in`  in  1  reset, asynchronous, active-low.
- `enable`  in  1  active-video flag from the timing generator.
- `current_row`  in  10  pixel coordinate, 48-pixel cell pitch.
- `current_line`  in  10  pixel coordinate, 64-pixel cell pitch.
- `wr_valid` / `wr_ready`  in / out  1  write handshake.
- `wr_x`, `wr_y`  in  4  target cell. `wr_status`  in  2  value to write.
- `fire_valid` / `fire_ready`  in / out  1  fire handshake.
- `fire_x`, `fire_y`  in  4  target cell.
- `fire_done`  out  1  one-cycle pulse when a fire completes.
- `fire_result`  out  2  cell status after the fire; valid with `fire_done`.
- `fire_err`  out  1  with `fire_done`: coordinate out of range.
- `clear_req`  in  1  level; clears the whole board.
- `clear_done`  out  1  one-cycle pulse at the end of a clear.
- `busy`  out  1  FSM is not in IDLE.
- `cell_status`  out  2  status of the cell under the pixel, to the driver.
- `cell_x`, `cell_y`  out  4  indices of that cell, to the driver.

## Operation
- Status encoding: 00 empty, 01 ship, 10 hit, 11 miss.
- Display lookup:
  - x = `current_line`/64; y = `current_row`/48, computed by comparing against constant multiples of 48 (no divider).
  - If x<COLS and y<ROWS, output the board entry.
  - Otherwise `cell_status`=00 and `cell_x`=`cell_y`=4'hF.
  - When `enable`=0, outputs hold their last value.
- FSM states: IDLE, CLEAR, FIRE_RD, FIRE_WR.
- Grant rule: a request is granted only in IDLE with `enable`=0. Priority is clear > fire > write.
  - `fire_ready` = IDLE & !`enable` & !`clear_req`.
  - `wr_ready` = `fire_ready` & !`fire_valid`.
- Write: on `wr_valid`&`wr_ready`, the cell updates at that clock edge. FSM stays in IDLE. An out-of-range coordinate is accepted and dropped.
- Fire:
  - On accept, capture the coordinates and go to FIRE_RD (read the cell), then FIRE_WR.
  - Update rule: 01->10, 00->11; 10 and 11 are unchanged.
  - In FIRE_WR, write the cell, pulse `fire_done` with `fire_result` = new value, then return to IDLE.
  - Out-of-range: no write; `fire_result`=00 and `fire_err`=1 with `fire_done`.
- Clear:
  - In IDLE with `enable`=0 and `clear_req`=1, enter CLEAR.
  - A 7-bit index sweeps 0..99, writing 00 at one cell per clock, regardless of `enable`.
  - At index 99, pulse `clear_done` and return to IDLE.
  - During CLEAR, `cell_status` is forced to 00.
  - `clear_req` still high in IDLE after a clear starts another clear.

## Timing
- Reset values: board all 00; FSM IDLE; `cell_status`=00; `cell_x`=`cell_y`=4'hF; `fire_done`=`fire_result`=`fire_err`=`clear_done`=`busy`=0.
- Display latency is 1 clock: outputs registered from the pixel coordinates of the previous cycle. The driver compensates with a matching coordinate register.
- A write is visible to the display lookup on the next clock.
- Fire: accept edge -> FIRE_RD -> FIRE_WR. `fire_done` is high in the 2nd cycle after the accept edge. A fire takes 2 cycles; `busy` is high for those 2.
- Clear takes 100 cycles of `busy`. `clear_done` is coincident with the index-99 write.
- `enable` rising during FIRE_RD or FIRE_WR does not abort the fire; it completes.
- Reset asserted mid-operation: immediate return to reset values. Any partial clear or fire is abandoned, and the board is reset to 00.

## Structure
- Shared package `battleship_pkg`:
  - status encodings: EMPTY, SHIP, HIT, MISS.
  - ROW_PERIOD=48, LINE_PERIOD=64, BOARD_CELLS=100.
  - FSM state typedef.
- One sub-module, `pixel_to_cell`: combinational pixel-to-cell mapping producing x, y and an in-range flag. The scheduler registers its outputs.

## Test plan
- Reset, then drive pixel (row=100, line=130) with `enable`=1 -> after 1 clock `cell_x`=2, `cell_y`=2, `cell_status`=00.
- `enable`=0, write (3,4)=01, then drive line=200, row=200 with `enable`=1 -> `cell_x`=3, `cell_y`=4, `cell_status`=01.
- Fire (3,4) after the ship write -> `fire_done` 2 clocks after accept, `fire_result`=10. Fire again -> `fire_result`=10 (no change). Fire (0,0) -> 11.
- `wr_valid` held while `enable`=1 -> `wr_ready`=0 throughout. Drop `enable` -> accepted on the first blanking clock.
- Simultaneous `clear_req` + `fire_valid` + `wr_valid` in blanking -> CLEAR wins. `clear_done` after 100 clocks, every cell reads 00, then the fire is granted.
- Fire (12,0) -> `fire_err`=1, `fire_result`=00, board unchanged. Reset asserted at clear index 50 -> all outputs at reset values at once, `busy`=0.
